// File: rtl/super_memory_vstage.sv
// Unified MEM stage: single-cycle scalar word access and lane-serial vector
// element access sharing one data memory and one MEM/WB output register.
module super_memory_vstage #(
   parameter int VECT_LANES = 3,
   parameter int MEMO_LINES = 64,
   parameter int REGI_SIZE  = 16,
   parameter int ELEM_SIZE  = 8
) (
   input  logic                            clk_i,
   input  logic                            rst_i,
   input  logic                            valid_i,
   input  logic                            isVector_i,
   input  logic                            flagMemRead_i,
   input  logic                            flagMemWrite_i,
   input  logic                            enableReg_i,
   input  logic                            enableJump_i,
   input  logic [REGI_SIZE-1:0]            int_a_i,
   input  logic [REGI_SIZE-1:0]            int_wd_i,
   input  logic [VECT_LANES*ELEM_SIZE-1:0] vec_wd_i,
   output logic                            stall_o,
   output logic                            valid_o,
   output logic [REGI_SIZE-1:0]            int_rd_o,
   output logic [VECT_LANES*ELEM_SIZE-1:0] vec_rd_o,
   output logic                            enableReg_o,
   output logic                            enableJump_o,
   output logic                            flagMemWrite_o,
   output logic                            addrErr_o
);

   localparam int ADDR_BITS = $clog2(MEMO_LINES);
   localparam int CNT_BITS  = $clog2(VECT_LANES) + 1;
   localparam int VEC_W     = VECT_LANES * ELEM_SIZE;
   // Addresses are compared one bit wider than a word so base+lane never wraps.
   localparam logic [REGI_SIZE:0]  MEM_LIMIT = (REGI_SIZE+1)'(MEMO_LINES);
   localparam logic [CNT_BITS-1:0] LAST_LANE = CNT_BITS'(VECT_LANES - 1);

   typedef enum logic {IDLE, VBUSY} state_t;

   state_t                state_q;
   logic [REGI_SIZE-1:0]  mem_q [MEMO_LINES];
   logic [CNT_BITS-1:0]   cnt_q;
   logic [REGI_SIZE-1:0]  base_q;
   logic [VEC_W-1:0]      vwd_q, vacc_q;
   logic                  rd_q, wr_q, en_reg_q, en_jmp_q, err_acc_q;

   logic                  accept;
   logic [REGI_SIZE:0]    s_addr, lane_addr;
   logic                  s_ok, l_ok;
   logic [REGI_SIZE-1:0]  s_rd_data;
   logic [ELEM_SIZE-1:0]  lane_wd, l_rd_data;
   logic [VEC_W-1:0]      vacc_d;
   logic                  err_d;
   logic                  mem_we_d;
   logic [ADDR_BITS-1:0]  mem_idx_d;
   logic [REGI_SIZE-1:0]  mem_wd_d;

   // A request is taken only from IDLE with no stall and outside reset.
   assign accept    = valid_i && !stall_o && (state_q == IDLE) && !rst_i;

   assign s_addr    = {1'b0, int_a_i};
   assign s_ok      = s_addr < MEM_LIMIT;
   assign s_rd_data = s_ok ? mem_q[int_a_i[ADDR_BITS-1:0]] : '0;

   assign lane_addr = {1'b0, base_q} + (REGI_SIZE+1)'(cnt_q);
   assign l_ok      = lane_addr < MEM_LIMIT;
   assign lane_wd   = vwd_q[cnt_q*ELEM_SIZE +: ELEM_SIZE];
   assign l_rd_data = l_ok ? mem_q[lane_addr[ADDR_BITS-1:0]][ELEM_SIZE-1:0] : '0;

   // Merge the current lane's read element and range error into the accumulators.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      vacc_d = vacc_q;
      err_d  = err_acc_q;
      if (rd_q) vacc_d[cnt_q*ELEM_SIZE +: ELEM_SIZE] = l_rd_data;
      if ((rd_q || wr_q) && !l_ok) err_d = 1'b1;
   end

   // Single write port: vector lane while busy, otherwise an accepted scalar write.
   always_comb begin
      mem_we_d  = 1'b0;
      mem_idx_d = '0;
      mem_wd_d  = '0;
      if (!rst_i) begin
         if (state_q == VBUSY) begin
            if (wr_q && l_ok) begin
               mem_we_d  = 1'b1;
               mem_idx_d = lane_addr[ADDR_BITS-1:0];
               mem_wd_d  = REGI_SIZE'(lane_wd);
            end
         end else if (accept && !isVector_i && flagMemWrite_i && s_ok) begin
            mem_we_d  = 1'b1;
            mem_idx_d = int_a_i[ADDR_BITS-1:0];
            mem_wd_d  = int_wd_i;
         end
      end
   end

   // Data memory array; reads elsewhere see the pre-write contents.
   always_ff @(posedge clk_i) begin
      // NOTE: the memory array has no reset; contents survive rst_i by design.
      if (mem_we_d) mem_q[mem_idx_d] <= mem_wd_d;
   end

   // Control FSM with registered MEM/WB outputs.
   always_ff @(posedge clk_i) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (rst_i) begin
         state_q        <= IDLE;
         cnt_q          <= '0;
         base_q         <= '0;
         vwd_q          <= '0;
         vacc_q         <= '0;
         rd_q           <= 1'b0;
         wr_q           <= 1'b0;
         en_reg_q       <= 1'b0;
         en_jmp_q       <= 1'b0;
         err_acc_q      <= 1'b0;
         stall_o        <= 1'b0;
         valid_o        <= 1'b0;
         int_rd_o       <= '0;
         vec_rd_o       <= '0;
         enableReg_o    <= 1'b0;
         enableJump_o   <= 1'b0;
         flagMemWrite_o <= 1'b0;
         addrErr_o      <= 1'b0;
      end else begin
         valid_o        <= 1'b0;
         enableReg_o    <= 1'b0;
         enableJump_o   <= 1'b0;
         flagMemWrite_o <= 1'b0;
         case (state_q)
            IDLE: begin
               if (accept) begin
                  if (isVector_i) begin
                     state_q   <= VBUSY;
                     stall_o   <= 1'b1;
                     cnt_q     <= '0;
                     base_q    <= int_a_i;
                     vwd_q     <= vec_wd_i;
                     vacc_q    <= '0;
                     err_acc_q <= 1'b0;
                     rd_q      <= flagMemRead_i;
                     wr_q      <= flagMemWrite_i;
                     en_reg_q  <= enableReg_i;
                     en_jmp_q  <= enableJump_i;
                  end else begin
                     valid_o        <= 1'b1;
                     int_rd_o       <= flagMemRead_i ? s_rd_data : '0;
                     vec_rd_o       <= '0;
                     addrErr_o      <= (flagMemRead_i || flagMemWrite_i) && !s_ok;
                     enableReg_o    <= enableReg_i;
                     enableJump_o   <= enableJump_i;
                     flagMemWrite_o <= flagMemWrite_i;
                  end
               end
            end
            VBUSY: begin
               vacc_q    <= vacc_d;
               err_acc_q <= err_d;
               cnt_q     <= cnt_q + 1'b1;
               if (cnt_q == LAST_LANE) begin
                  state_q        <= IDLE;
                  stall_o        <= 1'b0;
                  valid_o        <= 1'b1;
                  int_rd_o       <= '0;
                  vec_rd_o       <= vacc_d;
                  addrErr_o      <= err_d;
                  enableReg_o    <= en_reg_q;
                  enableJump_o   <= en_jmp_q;
                  flagMemWrite_o <= wr_q;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/super_memory_vstage.md
Name: super_memory_vstage

Overview:
- Unified MEM stage: scalar (int) and vector data memory access behind one MEM/WB pipeline register.
- Scalar access completes in one cycle.
- Vector access is lane-serial: one element per cycle, driven by a small FSM, with a stall back to the pipeline.
- Sits between EX/MEM and writeback, forwarding writeback/jump control alongside the data.

Parameters:
- VECT_LANES, 3, number of elements per vector access.
- MEMO_LINES, 64, memory depth in REGI_SIZE-bit words.
- REGI_SIZE, 16, scalar word and address width.
- ELEM_SIZE, 8, vector element width (ELEM_SIZE <= REGI_SIZE).
- ADDR_BITS (localparam), clog2(MEMO_LINES), memory index width.
- CNT_BITS (localparam), clog2(VECT_LANES)+1, lane counter width.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous, active-high reset.
- valid_i  in  1  request present this cycle.
- isVector_i  in  1  1 = vector access, 0 = scalar.
- flagMemRead_i  in  1  read request.
- flagMemWrite_i  in  1  write request.
- enableReg_i  in  1  writeback enable, passed through.
- enableJump_i  in  1  jump enable, passed through.
- int_a_i  in  REGI_SIZE  word address (vector base address).
- int_wd_i  in  REGI_SIZE  scalar write data.
- vec_wd_i  in  VECT_LANES*ELEM_SIZE  vector write data; lane k = bits [k*ELEM_SIZE +: ELEM_SIZE].
- stall_o  out  1  stage busy; upstream holds and valid_i is ignored.
- valid_o  out  1  registered result valid.
- int_rd_o  out  REGI_SIZE  scalar read data.
- vec_rd_o  out  VECT_LANES*ELEM_SIZE  vector read data.
- enableReg_o, enableJump_o, flagMemWrite_o  out  1 each  registered control, gated by valid_o.
- addrErr_o  out  1  registered: some accessed address was >= MEMO_LINES.

Behaviour:
- Interface: single clock clk_i; rst_i is synchronous and active-high.
- Reset:
  - FSM goes to IDLE; lane counter = 0.
  - All outputs = 0 (stall_o, valid_o, int_rd_o, vec_rd_o, control, addrErr_o).
  - Memory contents are not cleared.
  - Reset mid-vector aborts the access: lanes already written stay written, and valid_o does not assert for the aborted request.
- Accept: a request is accepted when valid_i=1, stall_o=0 and FSM=IDLE, at the rising edge.
- Scalar (isVector_i=0), accepted in cycle N:
  - Write: mem[int_a_i] <= int_wd_i at the edge closing cycle N.
  - Read: int_rd_o registered at the same edge; valid_o=1 during cycle N+1. Latency 1; stall_o stays 0.
  - Read+write together: int_rd_o returns the pre-write value (read-before-write).
  - Read not set: int_rd_o = 0.
- Vector (isVector_i=1), accepted in cycle N:
  - Latch the address, write data, flags and control; FSM IDLE->VBUSY; counter k=0.
  - VBUSY cycles N+1..N+VECT_LANES: stall_o=1; process lane k at address a+k, then k++.
  - Write: mem[a+k] <= zero-extend(vec_wd lane k).
  - Read: vec_rd lane k <= mem[a+k][ELEM_SIZE-1:0], pre-write value.
  - After lane VECT_LANES-1: FSM->IDLE; valid_o=1 during cycle N+VECT_LANES+1; stall_o=0 in that cycle, so a new request may be accepted.
  - int_rd_o = 0 for vector results; vec_rd_o = 0 for scalar results.
  - Read not set: vec_rd_o = 0.
- Address range:
  - Any address >= MEMO_LINES suppresses that write and reads 0.
  - addrErr_o=1 with that result; vector lanes are checked individually.
  - a+k is computed at REGI_SIZE+1 bits, with no wrap.
- No-request cycles: valid_o, enableReg_o, enableJump_o, flagMemWrite_o = 0; int_rd_o/vec_rd_o/addrErr_o hold their last values.
- Neither read nor write set with valid_i=1: a control-only pass-through with latency 1 (scalar) or VECT_LANES+1 (vector).
- valid_i while stall_o=1: ignored; no side effects.

Test Plan:
- Reset: assert rst_i for 2 cycles mid-traffic -> every output 0, stall_o=0, FSM IDLE.
- Scalar write then read: write a=5, wd=0xBEEF; read a=5 next cycle -> int_rd_o=0xBEEF with valid_o=1 exactly one cycle after the read accept, enableReg_o follows enableReg_i.
- Vector write/read: vector write base=10, vec_wd={0x33,0x22,0x11} -> stall_o high 3 cycles; a vector read base=10 then returns vec_rd_o={0x33,0x22,0x11} at accept+4, and a scalar read a=11 -> 0x0022.
- Boundary: vector write base=62, VECT_LANES=3 -> mem[62], mem[63] written, lane 2 dropped, addrErr_o=1. Scalar read a=64 -> int_rd_o=0, addrErr_o=1.
- Stall discipline: drive valid_i with write a=7 every cycle during VBUSY -> mem[7] unchanged; a request presented in the valid_o cycle is accepted.
- Abort: pulse rst_i during lane 1 of a vector write base=20 -> mem[20] written, mem[21..22] untouched, valid_o never asserts for that request.
